// File: rtl/axis_header_insert_align.sv
// AXI-Stream header inserter: prepends 0..W header bytes to each packet and
// re-packs the payload so every output beat is full except the last.
module axis_header_insert_align #(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
  output logic                    ready_insert
);

  localparam int unsigned SUM_WD = BYTE_CNT_WD + 1;
  localparam logic [BYTE_CNT_WD-1:0] W_CNT = BYTE_CNT_WD'(DATA_BYTE_WD);
  localparam logic [SUM_WD-1:0]      W_SUM = SUM_WD'(DATA_BYTE_WD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_FLUSH
  } state_e;

  state_e                   state_q, state_d;
  logic [BYTE_CNT_WD-1:0]   r_q, r_d;
  logic [DATA_WD-1:0]       res_q, res_d;
  logic                     valid_q, valid_d;
  logic [DATA_WD-1:0]       data_q, data_d;
  logic [DATA_BYTE_WD-1:0]  keep_q, keep_d;
  logic                     last_q, last_d;

  logic                     adv_c;
  logic [BYTE_CNT_WD-1:0]   hdr_cnt_c;
  logic [BYTE_CNT_WD-1:0]   pay_cnt_c;
  logic [SUM_WD-1:0]        sum_c;
  logic [DATA_WD-1:0]       hdr_res_c;
  logic [DATA_WD-1:0]       pay_data_c;
  logic [2*DATA_WD-1:0]     cat_c;
  logic                     unused_keep_insert;

  // Keep mask with the top nb bytes enabled (byte 0 is the MSB).
  function automatic logic [DATA_BYTE_WD-1:0] top_mask(input logic [SUM_WD-1:0] nb);
    logic [DATA_BYTE_WD-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
      if (SUM_WD'(i) < nb) m[DATA_BYTE_WD-1-i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [BYTE_CNT_WD-1:0] popcnt(input logic [DATA_BYTE_WD-1:0] k);
    logic [BYTE_CNT_WD-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
      c = c + BYTE_CNT_WD'(k[i]);
    end
    return c;
  endfunction

  // Zero disabled bytes so they never pollute the residual via the OR-merge.
  function automatic logic [DATA_WD-1:0] keep_data(input logic [DATA_WD-1:0] d,
                                                   input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
      r[8*i +: 8] = k[i] ? d[8*i +: 8] : 8'h00;
    end
    return r;
  endfunction

  assign unused_keep_insert = ^keep_insert;

  assign adv_c        = !valid_q || ready_out;
  assign ready_insert = (state_q == S_IDLE) && adv_c;
  assign ready_in     = (state_q == S_STREAM) && adv_c;

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign keep_out  = keep_q;
  assign last_out  = last_q;

  // Residual is kept MSB-aligned with all bytes past R forced to zero.
  assign hdr_cnt_c  = (byte_insert_cnt > W_CNT) ? W_CNT : byte_insert_cnt;
  assign hdr_res_c  = data_insert << {W_CNT - hdr_cnt_c, 3'b000};
  assign pay_cnt_c  = popcnt(keep_in);
  assign sum_c      = SUM_WD'(r_q) + SUM_WD'(pay_cnt_c);
  assign pay_data_c = keep_data(data_in, keep_in);
  assign cat_c      = {res_q, {DATA_WD{1'b0}}}
                    | ({{DATA_WD{1'b0}}, pay_data_c} << {W_CNT - r_q, 3'b000});

  // Next-state and output-register computation.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    res_d   = res_q;
    valid_d = valid_q && !ready_out;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (valid_insert && adv_c) begin
          state_d = S_STREAM;
          if (hdr_cnt_c == W_CNT) begin
            valid_d = 1'b1;
            data_d  = data_insert;
            keep_d  = '1;
            last_d  = 1'b0;
            r_d     = '0;
            res_d   = '0;
          end else begin
            r_d   = hdr_cnt_c;
            res_d = hdr_res_c;
          end
        end
      end
      S_STREAM: begin
        if (valid_in && adv_c) begin
          valid_d = 1'b1;
          data_d  = cat_c[2*DATA_WD-1 -: DATA_WD];
          if (!last_in) begin
            keep_d = '1;
            last_d = 1'b0;
            res_d  = cat_c[DATA_WD-1:0];
          end else if (sum_c <= W_SUM) begin
            keep_d  = top_mask(sum_c);
            last_d  = 1'b1;
            r_d     = '0;
            res_d   = '0;
            state_d = S_IDLE;
          end else begin
            keep_d  = '1;
            last_d  = 1'b0;
            r_d     = BYTE_CNT_WD'(sum_c - W_SUM);
            res_d   = cat_c[DATA_WD-1:0];
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (adv_c) begin
          valid_d = 1'b1;
          data_d  = res_q;
          keep_d  = top_mask(SUM_WD'(r_q));
          last_d  = 1'b1;
          r_d     = '0;
          res_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_axis_header_insert_align.sv
// Directed bench for axis_header_insert_align with W=4 and hand-computed beats.
module tb_axis_header_insert_align;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0]  keep_in = '0;
  logic        last_in = 1'b0;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out = 1'b1;
  logic        valid_insert = 1'b0;
  logic [31:0] data_insert = '0;
  logic [3:0]  keep_insert = '0;
  logic [2:0]  byte_insert_cnt = '0;
  logic        ready_insert;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  beat_t got[$];
  beat_t exp_q[$];
  beat_t mon_b;
  int n_tests = 0;
  int n_fail  = 0;

  axis_header_insert_align dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out),
    .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
    .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert)
  );

  always #5 clk = ~clk;

  // Inputs only change just after posedge, so the negedge view equals the next handshake.
  always @(negedge clk) begin
    if (rst_n && valid_out && ready_out) begin
      mon_b = {data_out, keep_out, last_out};
      got.push_back(mon_b);
    end
  end

  function automatic logic [31:0] bm(input logic [3:0] k);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  function automatic void ex(input logic [31:0] d, input logic [3:0] k, input logic l);
    beat_t b;
    b = {d, k, l};
    exp_q.push_back(b);
  endfunction

  task automatic start_test();
    got.delete();
    exp_q.delete();
    ready_out = 1'b1;
  endtask

  task automatic send_hdr(input logic [2:0] cnt, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    valid_insert    = 1'b1;
    data_insert     = d;
    byte_insert_cnt = cnt;
    keep_insert     = (cnt >= 3'd4) ? 4'hF : 4'((5'd1 << cnt) - 5'd1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ready_insert) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    valid_insert = 1'b0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL hdr_accept ready_insert=%b after 100 cycles, required 1", ready_insert);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit ok;
    ok = 1'b0;
    valid_in = 1'b1;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ready_in) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    last_in  = 1'b0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL beat_accept ready_in=%b after 100 cycles, required 1", ready_in);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && got.size() < exp_q.size(); i++) @(negedge clk);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if (valid_out !== 1'b0 || last_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid_last got v=%b l=%b required 0 0", valid_out, last_out);
    end
    n_tests++;
    if (data_out !== 32'h0 || keep_out !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_data_keep got d=%h k=%b required 00000000 0000", data_out, keep_out);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (ready_insert !== 1'b1 || ready_in !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready got ri=%b rin=%b required 1 0", ready_insert, ready_in);
    end
  endtask

  task automatic test_h2();
    start_test();
    ex(32'hAABB1122, 4'b1111, 1'b0);
    ex(32'h33445566, 4'b1111, 1'b1);
    send_hdr(3'd2, 32'h0000AABB);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h55667788, 4'b1100, 1'b1);
    drain();
    n_tests++;
    if (got.size() != exp_q.size()) begin
      n_fail++; $display("FAIL h2_count got %0d beats required %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      n_tests++;
      if ((got[i].d & bm(exp_q[i].k)) !== (exp_q[i].d & bm(exp_q[i].k)) ||
          got[i].k !== exp_q[i].k || got[i].l !== exp_q[i].l) begin
        n_fail++;
        $display("FAIL h2_beat%0d got d=%h k=%b l=%b required d=%h k=%b l=%b", i,
                 got[i].d, got[i].k, got[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
      end
    end
  endtask

  task automatic test_h3_flush();
    start_test();
    ex(32'hAABBCC11, 4'b1111, 1'b0);
    ex(32'h22330000, 4'b1100, 1'b1);
    send_hdr(3'd3, 32'h00AABBCC);
    send_beat(32'h11223344, 4'b1110, 1'b1);
    drain();
    n_tests++;
    if (got.size() != exp_q.size()) begin
      n_fail++; $display("FAIL h3_count got %0d beats required %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      n_tests++;
      if ((got[i].d & bm(exp_q[i].k)) !== (exp_q[i].d & bm(exp_q[i].k)) ||
          got[i].k !== exp_q[i].k || got[i].l !== exp_q[i].l) begin
        n_fail++;
        $display("FAIL h3_beat%0d got d=%h k=%b l=%b required d=%h k=%b l=%b", i,
                 got[i].d, got[i].k, got[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
      end
    end
  endtask

  task automatic test_h4_full_header();
    start_test();
    ex(32'hDEADBEEF, 4'b1111, 1'b0);
    ex(32'h01020304, 4'b1111, 1'b0);
    ex(32'h05060708, 4'b1111, 1'b1);
    send_hdr(3'd4, 32'hDEADBEEF);
    send_beat(32'h01020304, 4'b1111, 1'b0);
    send_beat(32'h05060708, 4'b1111, 1'b1);
    drain();
    n_tests++;
    if (got.size() != exp_q.size()) begin
      n_fail++; $display("FAIL h4_count got %0d beats required %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      n_tests++;
      if ((got[i].d & bm(exp_q[i].k)) !== (exp_q[i].d & bm(exp_q[i].k)) ||
          got[i].k !== exp_q[i].k || got[i].l !== exp_q[i].l) begin
        n_fail++;
        $display("FAIL h4_beat%0d got d=%h k=%b l=%b required d=%h k=%b l=%b", i,
                 got[i].d, got[i].k, got[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
      end
    end
  endtask

  task automatic test_h0_passthrough();
    start_test();
    ex(32'hA1A2A3A4, 4'b1111, 1'b0);
    ex(32'hB1B20000, 4'b1100, 1'b1);
    send_hdr(3'd0, 32'h12345678);
    send_beat(32'hA1A2A3A4, 4'b1111, 1'b0);
    send_beat(32'hB1B2C3D4, 4'b1100, 1'b1);
    drain();
    n_tests++;
    if (got.size() != exp_q.size()) begin
      n_fail++; $display("FAIL h0_count got %0d beats required %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      n_tests++;
      if ((got[i].d & bm(exp_q[i].k)) !== (exp_q[i].d & bm(exp_q[i].k)) ||
          got[i].k !== exp_q[i].k || got[i].l !== exp_q[i].l) begin
        n_fail++;
        $display("FAIL h0_beat%0d got d=%h k=%b l=%b required d=%h k=%b l=%b", i,
                 got[i].d, got[i].k, got[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
      end
    end
  endtask

  task automatic test_zero_keep();
    start_test();
    ex(32'h00000000, 4'b0000, 1'b1);
    ex(32'hCAFE0000, 4'b1100, 1'b1);
    send_hdr(3'd0, 32'h0);
    send_beat(32'h99999999, 4'b0000, 1'b1);
    send_hdr(3'd2, 32'h0000CAFE);
    send_beat(32'h77777777, 4'b0000, 1'b1);
    drain();
    n_tests++;
    if (got.size() != exp_q.size()) begin
      n_fail++; $display("FAIL zk_count got %0d beats required %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      n_tests++;
      if ((got[i].d & bm(exp_q[i].k)) !== (exp_q[i].d & bm(exp_q[i].k)) ||
          got[i].k !== exp_q[i].k || got[i].l !== exp_q[i].l) begin
        n_fail++;
        $display("FAIL zk_beat%0d got d=%h k=%b l=%b required d=%h k=%b l=%b", i,
                 got[i].d, got[i].k, got[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] snap_d;
    logic [3:0]  snap_k;
    logic        snap_l;
    start_test();
    ex(32'hAABB1122, 4'b1111, 1'b0);
    ex(32'h33445566, 4'b1111, 1'b0);
    ex(32'h778899AA, 4'b1111, 1'b0);
    ex(32'hBBCC0000, 4'b1100, 1'b1);
    fork
      begin
        send_hdr(3'd2, 32'h0000AABB);
        send_beat(32'h11223344, 4'b1111, 1'b0);
        send_beat(32'h55667788, 4'b1111, 1'b0);
        send_beat(32'h99AABBCC, 4'b1111, 1'b1);
      end
      begin
        for (int w = 0; w < 100 && got.size() < 1; w++) @(negedge clk);
        @(posedge clk); #1;
        ready_out = 1'b0;
        snap_d = data_out;
        snap_k = keep_out;
        snap_l = last_out;
        repeat (3) begin
          @(negedge clk);
          n_tests++;
          if (valid_out !== 1'b1 || data_out !== snap_d || keep_out !== snap_k ||
              last_out !== snap_l) begin
            n_fail++;
            $display("FAIL bp_hold got v=%b d=%h k=%b l=%b required v=1 d=%h k=%b l=%b",
                     valid_out, data_out, keep_out, last_out, snap_d, snap_k, snap_l);
          end
          n_tests++;
          if (ready_in !== 1'b0) begin
            n_fail++; $display("FAIL bp_ready_in got %b required 0", ready_in);
          end
        end
        @(posedge clk); #1;
        ready_out = 1'b1;
      end
    join
    drain();
    n_tests++;
    if (got.size() != exp_q.size()) begin
      n_fail++; $display("FAIL bp_count got %0d beats required %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      n_tests++;
      if ((got[i].d & bm(exp_q[i].k)) !== (exp_q[i].d & bm(exp_q[i].k)) ||
          got[i].k !== exp_q[i].k || got[i].l !== exp_q[i].l) begin
        n_fail++;
        $display("FAIL bp_beat%0d got d=%h k=%b l=%b required d=%h k=%b l=%b", i,
                 got[i].d, got[i].k, got[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
      end
    end
  endtask

  task automatic test_back_to_back();
    start_test();
    ex(32'hA0110000, 4'b1100, 1'b1);
    ex(32'hC1C2C3D1, 4'b1111, 1'b0);
    ex(32'hD2D3D4E1, 4'b1111, 1'b0);
    ex(32'hE2E3E4F1, 4'b1111, 1'b1);
    ex(32'h01234567, 4'b1111, 1'b0);
    ex(32'h89AB0000, 4'b1100, 1'b1);
    send_hdr(3'd1, 32'h000000A0);
    send_beat(32'h11223344, 4'b1000, 1'b1);
    send_hdr(3'd3, 32'h00C1C2C3);
    send_beat(32'hD1D2D3D4, 4'b1111, 1'b0);
    send_beat(32'hE1E2E3E4, 4'b1111, 1'b0);
    send_beat(32'hF1000000, 4'b1000, 1'b1);
    send_hdr(3'd7, 32'h01234567);
    send_beat(32'h89ABCDEF, 4'b1100, 1'b1);
    drain();
    n_tests++;
    if (got.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count got %0d beats required %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      n_tests++;
      if ((got[i].d & bm(exp_q[i].k)) !== (exp_q[i].d & bm(exp_q[i].k)) ||
          got[i].k !== exp_q[i].k || got[i].l !== exp_q[i].l) begin
        n_fail++;
        $display("FAIL b2b_beat%0d got d=%h k=%b l=%b required d=%h k=%b l=%b", i,
                 got[i].d, got[i].k, got[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    start_test();
    send_hdr(3'd2, 32'h0000AABB);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (valid_out !== 1'b0 || last_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_valid got v=%b l=%b required 0 0", valid_out, last_out);
    end
    n_tests++;
    if (data_out !== 32'h0 || keep_out !== 4'h0) begin
      n_fail++;
      $display("FAIL rstmid_data got d=%h k=%b required 00000000 0000", data_out, keep_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    got.delete();
    ex(32'hEE010203, 4'b1111, 1'b0);
    ex(32'h04000000, 4'b1000, 1'b1);
    send_hdr(3'd1, 32'h000000EE);
    send_beat(32'h01020304, 4'b1111, 1'b1);
    drain();
    n_tests++;
    if (got.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rstmid_count got %0d beats required %0d", got.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got.size()) begin
      n_tests++;
      if ((got[i].d & bm(exp_q[i].k)) !== (exp_q[i].d & bm(exp_q[i].k)) ||
          got[i].k !== exp_q[i].k || got[i].l !== exp_q[i].l) begin
        n_fail++;
        $display("FAIL rstmid_beat%0d got d=%h k=%b l=%b required d=%h k=%b l=%b", i,
                 got[i].d, got[i].k, got[i].l, exp_q[i].d, exp_q[i].k, exp_q[i].l);
      end
    end
  endtask

  initial begin
    test_reset();
    test_h2();
    test_h3_flush();
    test_h4_full_header();
    test_h0_passthrough();
    test_zero_keep();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
